// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel format and address packing for the scanout and the renderer.
package fb_pkg;

    localparam int unsigned FB_ADDR_W = 12;
    localparam int unsigned FB_DATA_W = 8;
    localparam int unsigned FB_COLS   = 64;
    localparam int unsigned FB_ROWS   = 64;
    localparam int unsigned WIN_W     = 256;
    localparam int unsigned WIN_H     = 256;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } pixel_t;

    // Side-band flags that travel alongside each beam position through the read latency.
    typedef struct packed {
        logic disp;
        logic in_win;
        logic issued;
        logic origin;
    } flags_t;

    localparam int unsigned FLAGS_W = $bits(flags_t);

    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [5:0] row,
                                                     input logic [5:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/fb_delay_line.sv
// Fixed-depth shift register used to align side-band flags with the RAM read latency.
module fb_delay_line #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            sr_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer read side: one RAM read per 4-pixel column group, 4x4 magnified scanout with border.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter logic [7:0]  BORDER      = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 display_on,
    input  logic [8:0]           hpos,
    input  logic [8:0]           vpos,
    output logic                 rd_en,
    output logic [FB_ADDR_W-1:0] rd_addr,
    input  logic [FB_DATA_W-1:0] rd_data,
    output logic                 pix_valid,
    output logic [FB_DATA_W-1:0] pix_data,
    output logic [2:0]           pix_r,
    output logic [2:0]           pix_g,
    output logic [1:0]           pix_b,
    output logic                 frame_start
);

    logic           in_win;
    logic           grp_start;
    flags_t         flags_in;
    flags_t         flags_out;
    logic [FB_DATA_W-1:0] hold_q;
    pixel_t         px;

    assign in_win    = display_on & ~hpos[8] & ~vpos[8];
    assign grp_start = in_win & (hpos[SCALE_SHIFT-1:0] == '0);

    assign flags_in = '{
        disp:   display_on,
        in_win: in_win,
        issued: grp_start,
        origin: display_on & (hpos == '0) & (vpos == '0)
    };

    // Depth RD_LAT+1 lands the flags in the same cycle as the read data they belong to.
    fb_delay_line #(
        .WIDTH(FLAGS_W),
        .DEPTH(RD_LAT + 1)
    ) u_delay (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (flags_in),
        .dout   (flags_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            hold_q      <= '0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            frame_start <= 1'b0;
        end else begin
            rd_en <= grp_start;
            if (grp_start) begin
                rd_addr <= fb_addr(vpos[7:2], hpos[7:2]);
            end
            if (flags_out.issued) begin
                hold_q <= rd_data;
            end
            pix_valid   <= flags_out.disp;
            frame_start <= flags_out.origin;
            // First pixel of a group bypasses the hold register; the other three reuse it.
            if (!flags_out.disp) begin
                pix_data <= '0;
            end else if (!flags_out.in_win) begin
                pix_data <= BORDER;
            end else if (flags_out.issued) begin
                pix_data <= rd_data;
            end else begin
                pix_data <= hold_q;
            end
        end
    end

    assign px    = pixel_t'(pix_data);
    assign pix_r = px.r;
    assign pix_g = px.g;
    assign pix_b = px.b;

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench: two scanouts (read latency 1 and 3) fed the same raster against a byte-array RAM.
module tb_fb_scanout;

    localparam logic [7:0] BRD   = 8'h1C;
    localparam int         LAT0  = 1 + 2;
    localparam int         LAT1  = 3 + 2;
    localparam int         H_TOT = 320;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       display_on = 1'b0;
    logic [8:0] hpos = '0;
    logic [8:0] vpos = '0;

    logic        rd_en0, rd_en1, pv0, pv1, fs0, fs1;
    logic [11:0] rd_addr0, rd_addr1;
    logic [7:0]  rd_data0, rd_data1, pd0, pd1;
    logic [2:0]  pr0, pr1, pg0, pg1;
    logic [1:0]  pb0, pb1;

    always #5 clk = ~clk;

    fb_scanout #(.RD_LAT(1), .SCALE_SHIFT(2), .BORDER(BRD)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .display_on(display_on), .hpos(hpos), .vpos(vpos),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0), .pix_valid(pv0),
        .pix_data(pd0), .pix_r(pr0), .pix_g(pg0), .pix_b(pb0), .frame_start(fs0)
    );

    fb_scanout #(.RD_LAT(3), .SCALE_SHIFT(2), .BORDER(BRD)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .display_on(display_on), .hpos(hpos), .vpos(vpos),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1), .pix_valid(pv1),
        .pix_data(pd1), .pix_r(pr1), .pix_g(pg1), .pix_b(pb1), .frame_start(fs1)
    );

    // RAM model: data only meaningful in the one cycle after a strobed read.
    logic [7:0] mem [4096];
    logic [7:0] ram0_q;
    logic [7:0] ram1_q [3];

    always @(posedge clk) begin
        ram0_q    <= rd_en0 ? mem[rd_addr0] : 8'hA5;
        ram1_q[0] <= rd_en1 ? mem[rd_addr1] : 8'h5A;
        ram1_q[1] <= ram1_q[0];
        ram1_q[2] <= ram1_q[1];
    end

    assign rd_data0 = ram0_q;
    assign rd_data1 = ram1_q[2];

    typedef struct {
        int         t;
        logic [7:0] d;
        logic       fs;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int rdcnt[2] = '{0, 0};
    int fscnt[2] = '{0, 0};
    int exp_reads = 0;
    int exp_fs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, idx, cyc, act, exp);
        end
    endtask

    task automatic mon(input int idx, input logic rd, input logic pv, input logic [7:0] pd,
                       input logic [2:0] r, input logic [2:0] g, input logic [1:0] b,
                       input logic fs);
        exp_t e;
        int   qs;
        if (!reset_n) begin
            chk("rst_rd_en", idx, rd, 0);
            chk("rst_pix_valid", idx, pv, 0);
            chk("rst_pix_data", idx, pd, 0);
            chk("rst_frame_start", idx, fs, 0);
        end else begin
            if (rd) rdcnt[idx]++;
            if (fs) fscnt[idx]++;
            if (pv) begin
                qs = (idx == 0) ? q0.size() : q1.size();
                if (qs == 0) begin
                    chk("unexpected_pixel", idx, pv, 0);
                end else begin
                    if (idx == 0) e = q0.pop_front();
                    else          e = q1.pop_front();
                    chk("latency", idx, cyc, e.t);
                    chk("pix_data", idx, pd, e.d);
                    chk("pix_rgb", idx, {r, g, b}, {e.d[7:5], e.d[4:2], e.d[1:0]});
                    chk("frame_start", idx, fs, e.fs);
                end
            end else begin
                chk("idle_pix_data", idx, pd, 0);
                chk("idle_frame_start", idx, fs, 0);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, rd_en0, pv0, pd0, pr0, pg0, pb0, fs0);
        mon(1, rd_en1, pv1, pd1, pr1, pg1, pb1, fs1);
    end

    // Reference: each displayed beam position shows its magnified byte, border, or nothing.
    task automatic drive(input logic d, input int h, input int v);
        exp_t e;
        display_on = d;
        hpos       = h[8:0];
        vpos       = v[8:0];
        if (d) begin
            if (h < 256 && v < 256) begin
                e.d = mem[(v / 4) * 64 + (h / 4)];
                if (h % 4 == 0) exp_reads++;
            end else begin
                e.d = BRD;
            end
            e.fs = (h == 0 && v == 0);
            if (e.fs) exp_fs++;
            e.t = cyc + LAT0;
            q0.push_back(e);
            e.t = cyc + LAT1;
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic line(input int v, input int act_end, input int rst_at);
        logic d;
        for (int h = 0; h < H_TOT; h++) begin
            if (h == rst_at) begin
                reset_n = 1'b0;
                display_on = 1'b0;
                q0.delete();
                q1.delete();
                #1;
                chk("async_rst_pix_valid", 0, pv0, 0);
                chk("async_rst_pix_data", 0, pd0, 0);
                chk("async_rst_rd_en", 1, rd_en1, 0);
                chk("async_rst_pix_data", 1, pd1, 0);
            end
            if (rst_at >= 0 && h == rst_at + 2) reset_n = 1'b1;
            d = (h < act_end) && !(rst_at >= 0 && h >= rst_at);
            drive(d, h, v);
        end
    endtask

    initial begin
        int vl[$];
        int act_end;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h047] = 8'hE3;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int f = 0; f < 3; f++) begin
            vl.delete();
            for (int v = 0; v < 8; v++) vl.push_back(v);
            for (int k = 0; k < 6; k++) vl.push_back(int'($urandom_range(8, 251)));
            vl.push_back(255);
            vl.push_back(256);
            vl.push_back(257);
            vl.push_back(300);
            foreach (vl[k]) begin
                act_end = (vl[k] >= 260) ? 0 : 280;
                if (f == 0 && vl[k] == 1) act_end = 130;
                else if (act_end != 0 && $urandom_range(0, 3) == 0)
                    act_end = int'($urandom_range(1, 279));
                if (f == 2 && vl[k] == 0) act_end = 0;
                line(vl[k], act_end, (f == 1 && vl[k] == 3) ? 100 : -1);
            end
        end
        for (int i = 0; i < 10; i++) drive(1'b0, 310, 300);
        chk("queue_drained", 0, q0.size(), 0);
        chk("queue_drained", 1, q1.size(), 0);
        chk("read_count", 0, rdcnt[0], exp_reads);
        chk("read_count", 1, rdcnt[1], exp_reads);
        chk("frame_start_count", 0, fscnt[0], exp_fs);
        chk("frame_start_count", 1, fscnt[1], exp_fs);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
